// File: rtl/mrr_rx_window_sched.sv
// mrr_rx_window_sched
//   Duty-cycle scheduler for the MRR gateway receive path. It opens periodic
//   listen windows on the AD9361 front end and lends the front end to a
//   single transmit requester in the gaps. A guard period is inserted every
//   time rf_enable rises, before RX listening starts or before TX is granted.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   cfg_enable        scheduler run
//   cfg_period        window period in clk cycles (0 = disabled)
//   cfg_window        listen length in clk cycles (0 behaves as 1)
//   tx_req, tx_done   transmit request level / one-cycle completion pulse
//   tx_grant          front end owned by the transmitter
//   rf_enable         ad9361 enable
//   rf_txnrx          ad9361 txnrx (1 = TX)
//   gw_enable         mrr_gateway enable
//   window_start      pulse on the first listen cycle
//   window_count      completed listen windows (saturating)
//   deferred_count    windows delayed by TX (saturating)
//   missed_count      windows dropped (saturating)
//   state             current FSM state
module mrr_rx_window_sched #(
   parameter int CNT_WIDTH    = 24,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_enable,
   input  logic [CNT_WIDTH-1:0] cfg_period,
   input  logic [CNT_WIDTH-1:0] cfg_window,
   input  logic                 tx_req,
   input  logic                 tx_done,
   output logic                 tx_grant,
   output logic                 rf_enable,
   output logic                 rf_txnrx,
   output logic                 gw_enable,
   output logic                 window_start,
   output logic [15:0]          window_count,
   output logic [7:0]           deferred_count,
   output logic [7:0]           missed_count,
   output logic [2:0]           state
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RX_GUARD  = 3'd1;
   localparam logic [2:0] S_RX_LISTEN = 3'd2;
   localparam logic [2:0] S_TX_GUARD  = 3'd3;
   localparam logic [2:0] S_TX_ACTIVE = 3'd4;

   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   logic [2:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] per_cnt, per_lat, per_eff;
   logic [CNT_WIDTH-1:0] win_len, win_cnt;
   logic [GW-1:0]        g_cnt;
   logic                 due;
   logic                 sched_en, win_event;
   logic                 in_rx, in_tx, guard_done, win_done, stay;

   assign state    = state_q;
   assign sched_en = cfg_enable && (cfg_period != '0);
   // A new period value takes effect only when the counter sits at 0, so a
   // mid-period write never truncates or stretches the running period.
   assign per_eff    = (per_cnt == '0) ? cfg_period : per_lat;
   assign win_event  = sched_en && (per_cnt == '0);
   assign in_rx      = (state_q == S_RX_GUARD) || (state_q == S_RX_LISTEN);
   assign in_tx      = (state_q == S_TX_GUARD) || (state_q == S_TX_ACTIVE);
   assign guard_done = (g_cnt == GUARD_LAST);
   assign win_done   = (win_cnt == win_len - ONE);
   assign stay       = (state_d == state_q);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            // RX wins over a simultaneous TX request.
            if (win_event || (due && cfg_enable)) state_d = S_RX_GUARD;
            else if (tx_req)                      state_d = S_TX_GUARD;
         end
         S_RX_GUARD: begin
            if (!cfg_enable)     state_d = S_IDLE;
            else if (guard_done) state_d = S_RX_LISTEN;
         end
         S_RX_LISTEN: begin
            if (!cfg_enable || win_done) state_d = S_IDLE;
         end
         S_TX_GUARD: begin
            if (!tx_req)         state_d = S_IDLE;
            else if (guard_done) state_d = S_TX_ACTIVE;
         end
         S_TX_ACTIVE: begin
            if (tx_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      rf_enable    = 1'b0;
      rf_txnrx     = 1'b0;
      gw_enable    = 1'b0;
      tx_grant     = 1'b0;
      window_start = 1'b0;
      case (state_q)
         S_RX_GUARD:  rf_enable = 1'b1;
         S_RX_LISTEN: begin
            rf_enable    = 1'b1;
            gw_enable    = 1'b1;
            window_start = (win_cnt == '0);
         end
         S_TX_GUARD:  begin
            rf_enable = 1'b1;
            rf_txnrx  = 1'b1;
         end
         S_TX_ACTIVE: begin
            rf_enable = 1'b1;
            rf_txnrx  = 1'b1;
            tx_grant  = 1'b1;
         end
         default: ;
      endcase
   end

   // Period counter, guard/window timers, pending flag and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt        <= '0;
         per_lat        <= '0;
         g_cnt          <= '0;
         win_cnt        <= '0;
         win_len        <= ONE;
         due            <= 1'b0;
         window_count   <= '0;
         deferred_count <= '0;
         missed_count   <= '0;
      end else begin
         if (!sched_en) begin
            per_cnt <= '0;
         end else begin
            if (per_cnt == '0) per_lat <= cfg_period;
            per_cnt <= (per_cnt == per_eff - ONE) ? '0 : per_cnt + ONE;
         end

         // Timers restart on every state change.
         g_cnt   <= (stay && (state_q == S_RX_GUARD || state_q == S_TX_GUARD)) ? g_cnt + GW'(1) : '0;
         win_cnt <= (stay && state_q == S_RX_LISTEN) ? win_cnt + ONE : '0;

         if (state_q == S_RX_GUARD && state_d == S_RX_LISTEN)
            win_len <= (cfg_window == '0) ? ONE : cfg_window;

         if (!cfg_enable)
            due <= 1'b0;
         else if (win_event && (state_q == S_IDLE || in_tx))
            due <= 1'b1;
         else if (state_q == S_RX_GUARD && state_d == S_RX_LISTEN)
            due <= 1'b0;

         if (state_q == S_RX_LISTEN && cfg_enable && win_done && window_count != '1)
            window_count <= window_count + 16'd1;

         // Only the first event during a TX session is deferred; any further
         // one would overwrite the same pending flag and is lost.
         if (win_event && in_tx && !due && deferred_count != '1)
            deferred_count <= deferred_count + 8'd1;

         if (win_event && (in_rx || (in_tx && due)) && missed_count != '1)
            missed_count <= missed_count + 8'd1;
      end
   end

endmodule
